// File: rtl/framebuffer_pkg.sv
// framebuffer_pkg
// Shared definitions for the line framebuffer: reader FSM states, panel
// geometry constants and the address mapping that the UART writer path also
// uses, so that both sides always agree on where a pixel byte lives.
package framebuffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } fb_state_t;

  localparam int PIXEL_COLS      = 64;
  localparam int HALF_ROWS       = 16;
  localparam int BYTES_PER_PIXEL = 2;
  localparam int FB_ADDR_WIDTH   = 12;

  // Columns are stored mirrored (~col) to match the panel wiring seen by the
  // writer; byte_sel=1 is RGB565[15:8], byte_sel=0 is RGB565[7:0].
  function automatic logic [FB_ADDR_WIDTH-1:0] fb_addr(
    input logic [4:0] row,
    input logic [5:0] col,
    input logic       byte_sel
  );
    return {row, ~col, byte_sel};
  endfunction

endpackage

// File: rtl/rgb565_plane_bit.sv
// rgb565_plane_bit
// Combinational bit-plane slicer for one RGB565 pixel.
// Ports:
//   pixel             RGB565 word {R5,G6,B5}
//   plane             bit-plane index, 5 = MSB; values above 5 give 0
//   rgb_enable        channel gates, bit0=R bit1=G bit2=B
//   brightness_enable per-plane gate, bit p gates plane p
//   rgb               selected plane bit as {B,G,R}
module rgb565_plane_bit #(
  parameter int BITPLANES = 6
) (
  input  logic [15:0]          pixel,
  input  logic [2:0]           plane,
  input  logic [2:0]           rgb_enable,
  input  logic [BITPLANES-1:0] brightness_enable,
  output logic [2:0]           rgb
);

  logic [5:0] r6;
  logic [5:0] g6;
  logic [5:0] b6;
  logic [7:0] r_w;
  logic [7:0] g_w;
  logic [7:0] b_w;
  logic [7:0] be_w;
  logic       plane_on;

  // 5-bit channels are widened by repeating their MSB into the new LSB.
  assign r6 = {pixel[15:11], pixel[15]};
  assign g6 = pixel[10:5];
  assign b6 = {pixel[4:0], pixel[4]};

  // Widen to 8 bits so every 3-bit plane index stays in range.
  assign r_w  = {2'b00, r6};
  assign g_w  = {2'b00, g6};
  assign b_w  = {2'b00, b6};
  assign be_w = 8'(brightness_enable);

  assign plane_on = (plane <= 3'd5) && be_w[plane];
  assign rgb      = plane_on ? ({b_w[plane], g_w[plane], r_w[plane]} & rgb_enable)
                             : 3'b000;

endmodule

// File: rtl/framebuffer_row_reader.sv
// framebuffer_row_reader
// Reads one scan-row pair (rows r and r+16) from the framebuffer RAM, slices
// one bit-plane out of every pixel and streams 64 two-row beats to the panel
// shift stage over valid/ready.
// Ports:
//   clk_in, reset          clock; synchronous active-low reset
//   start                  one-cycle request, honoured only in IDLE
//   row_sel, plane         upper row index and bit-plane, latched at start
//   rgb_enable             channel gates, latched at start
//   brightness_enable      per-plane gates, latched at start
//   ram_address/_read_enable/ram_data_in
//                          RAM read port, data one cycle after its address
//   pix_rgb_top/_bot       {B,G,R} plane bits of upper/lower pixel
//   pix_col, pix_last      beat column, high on column 63
//   pix_valid, pix_ready   beat handshake
//   busy, done             activity flag, one-cycle end-of-row pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// FETCH   | issuing the four byte reads of the current column, capturing
// PRESENT | beat held on pix_*; top-hi read of the next column in flight
// DONE    | done pulse, back to IDLE
module framebuffer_row_reader
  import framebuffer_pkg::*;
#(
  parameter int BITPLANES = 6
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               row_sel,
  input  logic [2:0]               plane,
  input  logic [2:0]               rgb_enable,
  input  logic [BITPLANES-1:0]     brightness_enable,
  output logic [FB_ADDR_WIDTH-1:0] ram_address,
  output logic                     ram_read_enable,
  input  logic [7:0]               ram_data_in,
  output logic [2:0]               pix_rgb_top,
  output logic [2:0]               pix_rgb_bot,
  output logic [5:0]               pix_col,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_last,
  output logic                     busy,
  output logic                     done
);

  localparam logic [5:0] LAST_COL       = 6'(PIXEL_COLS - 1);
  localparam logic [4:0] BOT_ROW_OFFSET = 5'(HALF_ROWS);
  localparam logic [1:0] LAST_SEL       = 2'(2 * BYTES_PER_PIXEL - 1);

  // Read slot encoding: 0 top-hi, 1 top-lo, 2 bot-hi, 3 bot-lo.
  function automatic logic [FB_ADDR_WIDTH-1:0] sel_addr(
    input logic [3:0] row,
    input logic [5:0] col_i,
    input logic [1:0] sel
  );
    logic [4:0] r5;
    r5 = sel[1] ? ({1'b0, row} | BOT_ROW_OFFSET) : {1'b0, row};
    return fb_addr(r5, col_i, ~sel[0]);
  endfunction

  fb_state_t             state;
  logic [5:0]            col;
  logic [3:0]            row_q;
  logic [2:0]            plane_q;
  logic [2:0]            rgb_en_q;
  logic [BITPLANES-1:0]  bright_q;
  logic [1:0]            issue_sel;
  logic                  cap_valid;
  logic [1:0]            cap_sel;
  logic [7:0]            top_hi;
  logic [7:0]            top_lo;
  logic [7:0]            bot_hi;
  logic [2:0]            top_bits;
  logic [2:0]            bot_bits;

  rgb565_plane_bit #(.BITPLANES(BITPLANES)) u_top_bit (
    .pixel             ({top_hi, top_lo}),
    .plane             (plane_q),
    .rgb_enable        (rgb_en_q),
    .brightness_enable (bright_q),
    .rgb               (top_bits)
  );

  // The bot-lo byte is consumed straight off the RAM bus in its data cycle.
  rgb565_plane_bit #(.BITPLANES(BITPLANES)) u_bot_bit (
    .pixel             ({bot_hi, ram_data_in}),
    .plane             (plane_q),
    .rgb_enable        (rgb_en_q),
    .brightness_enable (bright_q),
    .rgb               (bot_bits)
  );

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state           <= IDLE;
      col             <= '0;
      row_q           <= '0;
      plane_q         <= '0;
      rgb_en_q        <= '0;
      bright_q        <= '0;
      issue_sel       <= '0;
      cap_valid       <= 1'b0;
      cap_sel         <= '0;
      top_hi          <= '0;
      top_lo          <= '0;
      bot_hi          <= '0;
      ram_address     <= '0;
      ram_read_enable <= 1'b0;
      pix_rgb_top     <= '0;
      pix_rgb_bot     <= '0;
      pix_col         <= '0;
      pix_valid       <= 1'b0;
      pix_last        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      // Tag each read so its byte is captured in the following cycle,
      // whatever state the FSM has moved on to.
      cap_valid <= ram_read_enable;
      cap_sel   <= issue_sel;
      if (cap_valid) begin
        case (cap_sel)
          2'd0:    top_hi <= ram_data_in;
          2'd1:    top_lo <= ram_data_in;
          2'd2:    bot_hi <= ram_data_in;
          default: ;
        endcase
      end

      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            row_q           <= row_sel;
            plane_q         <= plane;
            rgb_en_q        <= rgb_enable;
            bright_q        <= brightness_enable;
            col             <= '0;
            issue_sel       <= 2'd0;
            ram_address     <= sel_addr(row_sel, 6'd0, 2'd0);
            ram_read_enable <= 1'b1;
            busy            <= 1'b1;
            state           <= FETCH;
          end
        end

        FETCH: begin
          if (ram_read_enable && (issue_sel != LAST_SEL)) begin
            issue_sel   <= issue_sel + 2'd1;
            ram_address <= sel_addr(row_q, col, issue_sel + 2'd1);
          end else begin
            ram_read_enable <= 1'b0;
          end

          if (cap_valid && (cap_sel == LAST_SEL)) begin
            pix_rgb_top <= top_bits;
            pix_rgb_bot <= bot_bits;
            pix_col     <= col;
            pix_last    <= (col == LAST_COL);
            pix_valid   <= 1'b1;
            state       <= PRESENT;
            // Start the next column's top-hi read while this beat is shown,
            // so an accepted beat costs five cycles instead of six.
            if (col != LAST_COL) begin
              issue_sel       <= 2'd0;
              ram_address     <= sel_addr(row_q, col + 6'd1, 2'd0);
              ram_read_enable <= 1'b1;
            end
          end
        end

        PRESENT: begin
          ram_read_enable <= 1'b0;
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (col == LAST_COL) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              col             <= col + 6'd1;
              issue_sel       <= 2'd1;
              ram_address     <= sel_addr(row_q, col + 6'd1, 2'd1);
              ram_read_enable <= 1'b1;
              state           <= FETCH;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_row_reader.sv
module tb_framebuffer_row_reader;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  row_sel = '0;
  logic [2:0]  plane = '0;
  logic [2:0]  rgb_enable = '0;
  logic [5:0]  brightness_enable = '0;
  logic [11:0] ram_address;
  logic        ram_read_enable;
  logic [7:0]  ram_data_in = '0;
  logic [2:0]  pix_rgb_top;
  logic [2:0]  pix_rgb_bot;
  logic [5:0]  pix_col;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_last;
  logic        busy;
  logic        done;

  framebuffer_row_reader #(.BITPLANES(6)) dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .start             (start),
    .row_sel           (row_sel),
    .plane             (plane),
    .rgb_enable        (rgb_enable),
    .brightness_enable (brightness_enable),
    .ram_address       (ram_address),
    .ram_read_enable   (ram_read_enable),
    .ram_data_in       (ram_data_in),
    .pix_rgb_top       (pix_rgb_top),
    .pix_rgb_bot       (pix_rgb_bot),
    .pix_col           (pix_col),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_last          (pix_last),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] mem [4096];
  always @(posedge clk_in) if (ram_read_enable) ram_data_in <= mem[ram_address];

  typedef struct {
    logic [15:0] top_px;
    logic [15:0] bot_px;
    logic [3:0]  row;
    logic [2:0]  pl;
    logic [2:0]  re;
    logic [5:0]  be;
    logic [2:0]  exp_top;
    logic [2:0]  exp_bot;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int errors = 0;

  int         r_first_cyc, r_first_col, r_beats, r_done_cyc, r_done_cnt, r_reads;
  int         r_order_bad, r_stall_bad;
  logic [2:0] r_first_top, r_first_bot, r_last_top, r_last_bot;
  logic       r_any_set, r_abort_ok;
  logic [11:0] r_addr1, r_addr4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic put_px(input logic [4:0] r, input logic [5:0] c, input logic [15:0] v);
    logic [5:0] nc;
    nc = ~c;
    mem[{r, nc, 1'b1}] = v[15:8];
    mem[{r, nc, 1'b0}] = v[7:0];
  endtask

  // Cycle 0 is the cycle in which start is driven; the task returns positioned
  // in the cycle after done (or 20 cycles after an abort).
  task automatic run_row(input logic [3:0] rs, input logic [2:0] pl, input logic [2:0] re,
                         input logic [5:0] be, input int stall_beat, input int stall_len,
                         input int restart_cyc, input int abort_cyc);
    int         stall_left;
    bit         stall_started;
    bit         saw_done;
    logic [12:0] snap;
    stall_left = 0; stall_started = 0; saw_done = 0; snap = '0;
    r_first_cyc = -1; r_first_col = -1; r_beats = 0; r_done_cyc = -1; r_done_cnt = 0;
    r_reads = 0; r_order_bad = 0; r_stall_bad = 0; r_any_set = 0; r_abort_ok = 0;
    r_first_top = '0; r_first_bot = '0; r_last_top = '0; r_last_bot = '0;
    r_addr1 = '0; r_addr4 = '0;
    for (int c = 0; c < 600; c++) begin
      start = (c == 0) || (c == restart_cyc);
      reset = (c != abort_cyc);
      if (c == 0) begin
        row_sel = rs; plane = pl; rgb_enable = re; brightness_enable = be;
      end else if (c == 1) begin
        row_sel = ~rs; plane = pl ^ 3'b101; rgb_enable = ~re; brightness_enable = ~be;
      end
      if (c == 1) r_addr1 = ram_address;
      if (c == 4) r_addr4 = ram_address;
      if (abort_cyc >= 0 && c == abort_cyc + 1)
        r_abort_ok = !busy && !pix_valid && !ram_read_enable && (ram_address == 12'h000)
                     && !done && !pix_last;
      if (ram_read_enable) r_reads++;
      if (done) begin r_done_cnt++; r_done_cyc = c; saw_done = 1; end
      pix_ready = 1'b1;
      if (pix_valid && !stall_started && pix_col == 6'(stall_beat) && stall_len > 0) begin
        stall_started = 1;
        stall_left = stall_len;
        snap = {pix_rgb_top, pix_rgb_bot, pix_col, pix_last};
      end
      if (stall_left > 0) begin
        pix_ready = 1'b0;
        if (!pix_valid || {pix_rgb_top, pix_rgb_bot, pix_col, pix_last} != snap) r_stall_bad++;
        // Only the first held cycle may carry the next column's prefetch read.
        if (stall_left < stall_len && ram_read_enable) r_stall_bad++;
        stall_left--;
      end
      if (pix_valid) begin
        if (r_first_cyc < 0) begin
          r_first_cyc = c; r_first_col = int'(pix_col);
          r_first_top = pix_rgb_top; r_first_bot = pix_rgb_bot;
        end
        if (pix_rgb_top != 3'b000 || pix_rgb_bot != 3'b000) r_any_set = 1;
        if (pix_ready) begin
          if (pix_col != 6'(r_beats) || pix_last != (pix_col == 6'd63)) r_order_bad++;
          if (pix_col == 6'd63) begin r_last_top = pix_rgb_top; r_last_bot = pix_rgb_bot; end
          r_beats++;
        end
      end
      tick();
      if (saw_done) break;
      if (abort_cyc >= 0 && c == abort_cyc + 20) break;
    end
    start = 1'b0;
    reset = 1'b1;
    pix_ready = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom_range(0, 255));

    //          top_px    bot_px    row   pl    re      be     exp_top exp_bot
    vecs[0] = '{16'hF800, 16'h0000, 4'd3,  3'd5, 3'b111, 6'h3F, 3'b001, 3'b000};
    vecs[1] = '{16'h0000, 16'hFFFF, 4'd3,  3'd2, 3'b111, 6'h3F, 3'b000, 3'b111};
    vecs[2] = '{16'h0000, 16'hFFFF, 4'd3,  3'd2, 3'b101, 6'h3F, 3'b000, 3'b101};
    vecs[3] = '{16'h0000, 16'hFFFF, 4'd3,  3'd2, 3'b111, 6'h3B, 3'b000, 3'b000};
    vecs[4] = '{16'h0000, 16'hFFFF, 4'd3,  3'd6, 3'b111, 6'h3F, 3'b000, 3'b000};
    vecs[5] = '{16'h8010, 16'h07E0, 4'd7,  3'd0, 3'b111, 6'h3F, 3'b101, 3'b010};
    vecs[6] = '{16'h7800, 16'h000F, 4'd15, 3'd1, 3'b111, 6'h3F, 3'b001, 3'b100};
    vecs[7] = '{16'h0400, 16'hFFFF, 4'd0,  3'd5, 3'b010, 6'h3F, 3'b010, 3'b010};

    // Reset state, and start ignored while reset is held.
    reset = 1'b0;
    tick(); tick();
    chk("reset_outputs", {ram_address, ram_read_enable, pix_rgb_top, pix_rgb_bot, pix_col,
                          pix_valid, pix_last, busy, done}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick(); tick(); tick();
    chk("start_in_reset_ignored", {busy, ram_read_enable, pix_valid}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      put_px({1'b0, vecs[i].row}, 6'd0,  vecs[i].top_px);
      put_px({1'b1, vecs[i].row}, 6'd0,  vecs[i].bot_px);
      put_px({1'b0, vecs[i].row}, 6'd63, vecs[i].top_px);
      put_px({1'b1, vecs[i].row}, 6'd63, vecs[i].bot_px);
      run_row(vecs[i].row, vecs[i].pl, vecs[i].re, vecs[i].be, -1, 0, -1, -1);
      chk($sformatf("v%0d_first_cycle", i), r_first_cyc, 6);
      chk($sformatf("v%0d_first_col", i), r_first_col, 0);
      chk($sformatf("v%0d_top", i), r_first_top, vecs[i].exp_top);
      chk($sformatf("v%0d_bot", i), r_first_bot, vecs[i].exp_bot);
      chk($sformatf("v%0d_last_top", i), r_last_top, vecs[i].exp_top);
      chk($sformatf("v%0d_last_bot", i), r_last_bot, vecs[i].exp_bot);
      chk($sformatf("v%0d_beats", i), r_beats, 64);
      chk($sformatf("v%0d_order", i), r_order_bad, 0);
      chk($sformatf("v%0d_done_cycle", i), r_done_cyc, 322);
      chk($sformatf("v%0d_done_count", i), r_done_cnt, 1);
      chk($sformatf("v%0d_reads", i), r_reads, 256);
      chk($sformatf("v%0d_addr_top_hi", i), r_addr1, {20'h0, 1'b0, vecs[i].row, 6'h3F, 1'b1});
      chk($sformatf("v%0d_addr_bot_lo", i), r_addr4, {20'h0, 1'b1, vecs[i].row, 6'h3F, 1'b0});
      chk($sformatf("v%0d_idle_after", i), {busy, pix_valid, done}, 32'h0);
      if (vecs[i].pl > 3'd5) chk($sformatf("v%0d_plane_off_all_zero", i), r_any_set, 0);
    end

    put_px(5'd3, 6'd0, 16'hF800);
    put_px(5'd19, 6'd0, 16'h0000);

    // Back-pressure: beat 10 held for 7 cycles.
    run_row(4'd3, 3'd5, 3'b111, 6'h3F, 10, 7, -1, -1);
    chk("bp_stable_no_read", r_stall_bad, 0);
    chk("bp_done_cycle", r_done_cyc, 329);
    chk("bp_beats", r_beats, 64);
    chk("bp_order", r_order_bad, 0);
    chk("bp_reads", r_reads, 256);

    // Start while busy is dropped.
    run_row(4'd3, 3'd5, 3'b111, 6'h3F, -1, 0, 50, -1);
    chk("busy_start_beats", r_beats, 64);
    chk("busy_start_done_count", r_done_cnt, 1);
    chk("busy_start_done_cycle", r_done_cyc, 322);
    chk("busy_start_top", r_first_top, 3'b001);

    // Reset mid-row.
    run_row(4'd3, 3'd5, 3'b111, 6'h3F, -1, 0, -1, 100);
    chk("abort_idle_next_cycle", r_abort_ok, 1);
    chk("abort_no_done", r_done_cnt, 0);
    chk("abort_busy_low", busy, 0);

    run_row(4'd3, 3'd5, 3'b111, 6'h3F, -1, 0, -1, -1);
    chk("after_abort_addr", r_addr1, 12'h1FF);
    chk("after_abort_first_cycle", r_first_cyc, 6);
    chk("after_abort_top", r_first_top, 3'b001);
    chk("after_abort_bot", r_first_bot, 3'b000);
    chk("after_abort_done_cycle", r_done_cyc, 322);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
